// File: rtl/global_trigger_ctrl.sv
// global_trigger_ctrl
//   Collects threshold-crossing requests from NUM_CH Thresholder channels.
//   A request opens a coincidence window of COINC_WIN cycles. When the window
//   closes, the block broadcasts the global trigger and holds it until readout
//   completes or MAX_WAIT cycles pass. It then stays dead for DEADTIME cycles.
//
// Ports
//   rx_std_clkout       sole clock, rising edge
//   rst_n               asynchronous active-low reset
//   ch_sync             per-channel link-synced flag
//   ch_enable           per-channel trigger enable mask
//   set_global_trigger  per-channel threshold-crossing request (level)
//   time_stamp          packed per-channel stamps, channel i at [i*TS_W +: TS_W]
//   readout_done        single-cycle pulse; the event has been consumed
//   Global_trigger_flag high while an event is being read out
//   trig_valid          single-cycle pulse; mask and stamp are valid
//   trig_ch_mask        channels that requested within the coincidence window
//   trig_time_stamp     stamp of the first (lowest-index) requesting channel
//   trig_count          accepted-trigger counter, wraps at 16 bits
//   timeout_err         sticky readout-timeout flag
//   busy                high in any state other than IDLE

module global_trigger_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int TS_W      = 16,
    parameter int COINC_WIN = 4,
    parameter int DEADTIME  = 16,
    parameter int MAX_WAIT  = 256
) (
    input  logic                   rx_std_clkout,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      ch_sync,
    input  logic [NUM_CH-1:0]      ch_enable,
    input  logic [NUM_CH-1:0]      set_global_trigger,
    input  logic [NUM_CH*TS_W-1:0] time_stamp,
    input  logic                   readout_done,
    output logic                   Global_trigger_flag,
    output logic                   trig_valid,
    output logic [NUM_CH-1:0]      trig_ch_mask,
    output logic [TS_W-1:0]        trig_time_stamp,
    output logic [15:0]            trig_count,
    output logic                   timeout_err,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        COINC,
        ASSERT,
        DEAD
    } state_t;

    // One shared cycle counter serves all timed states; each limit is the
    // last counter value before the state is left.
    localparam logic [15:0] COINC_LAST = 16'(COINC_WIN - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(MAX_WAIT - 1);
    localparam logic [15:0] DEAD_LAST  = 16'(DEADTIME - 1);

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       cnt;
    logic [15:0]       cnt_nxt;
    logic [NUM_CH-1:0] req;
    logic [TS_W-1:0]   first_ts;
    logic              first_found;
    logic [NUM_CH-1:0] mask_nxt;
    logic [TS_W-1:0]   ts_nxt;
    logic              valid_nxt;
    logic [15:0]       count_nxt;
    logic              terr_nxt;

    assign req = set_global_trigger & ch_enable & ch_sync;

    // Stamp of the lowest-index requesting channel.
    always_comb begin
        first_ts    = '0;
        first_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (req[i] && !first_found) begin
                first_ts    = time_stamp[i*TS_W +: TS_W];
                first_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mask_nxt  = trig_ch_mask;
        ts_nxt    = trig_time_stamp;
        valid_nxt = 1'b0;
        count_nxt = trig_count;
        terr_nxt  = timeout_err;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = COINC;
                    cnt_nxt   = '0;
                    mask_nxt  = req;
                    ts_nxt    = first_ts;
                end
            end
            COINC: begin
                mask_nxt = trig_ch_mask | req;
                if (cnt == COINC_LAST) begin
                    state_nxt = ASSERT;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b1;
                    count_nxt = trig_count + 16'd1;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ASSERT: begin
                // readout_done takes priority, so a readout on the expiry
                // edge counts as a normal completion.
                if (readout_done) begin
                    state_nxt = DEAD;
                    cnt_nxt   = '0;
                end else if (cnt == WAIT_LAST) begin
                    state_nxt = DEAD;
                    cnt_nxt   = '0;
                    terr_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            DEAD: begin
                if (cnt == DEAD_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            trig_ch_mask    <= '0;
            trig_time_stamp <= '0;
            trig_valid      <= 1'b0;
            trig_count      <= '0;
            timeout_err     <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            trig_ch_mask    <= mask_nxt;
            trig_time_stamp <= ts_nxt;
            trig_valid      <= valid_nxt;
            trig_count      <= count_nxt;
            timeout_err     <= terr_nxt;
        end
    end

    assign Global_trigger_flag = (state == ASSERT);
    assign busy                = (state != IDLE);

endmodule

// File: tb/tb_global_trigger_ctrl.sv
// tb_global_trigger_ctrl
//   Scoreboard bench for global_trigger_ctrl (NUM_CH=4, TS_W=16, COINC_WIN=4,
//   DEADTIME=16, MAX_WAIT=256). Expected events are queued when requests are
//   driven and compared when trig_valid pulses. Inputs change on the falling
//   edge, and outputs are sampled on the falling edge.

module tb_global_trigger_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ch_sync;
    logic [3:0]  ch_enable;
    logic [3:0]  sgt;
    logic [63:0] time_stamp;
    logic        readout_done;
    logic        flag;
    logic        trig_valid;
    logic [3:0]  trig_ch_mask;
    logic [15:0] trig_time_stamp;
    logic [15:0] trig_count;
    logic        timeout_err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c;
    int a;
    int d;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] ts;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    global_trigger_ctrl #(
        .NUM_CH(4),
        .TS_W(16),
        .COINC_WIN(4),
        .DEADTIME(16),
        .MAX_WAIT(256)
    ) dut (
        .rx_std_clkout(clk),
        .rst_n(rst_n),
        .ch_sync(ch_sync),
        .ch_enable(ch_enable),
        .set_global_trigger(sgt),
        .time_stamp(time_stamp),
        .readout_done(readout_done),
        .Global_trigger_flag(flag),
        .trig_valid(trig_valid),
        .trig_ch_mask(trig_ch_mask),
        .trig_time_stamp(trig_time_stamp),
        .trig_count(trig_count),
        .timeout_err(timeout_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [3:0] m, input logic [15:0] t, input logic [15:0] n, input int at);
        exp_t x;
        x.mask = m;
        x.ts   = t;
        x.cnt  = n;
        x.cyc  = at;
        sb.push_back(x);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_flag"},  flag,            0);
        chk({pfx, "_valid"}, trig_valid,      0);
        chk({pfx, "_mask"},  trig_ch_mask,    0);
        chk({pfx, "_ts"},    trig_time_stamp, 0);
        chk({pfx, "_count"}, trig_count,      0);
        chk({pfx, "_terr"},  timeout_err,     0);
        chk({pfx, "_busy"},  busy,            0);
    endtask

    // Scoreboard consumer: every trig_valid pulse must match the oldest
    // expected event, including the cycle on which it appears.
    always @(negedge clk) begin
        if (rst_n && trig_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", trig_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("ev_mask",    trig_ch_mask,    e.mask);
                chk("ev_ts",      trig_time_stamp, e.ts);
                chk("ev_count",   trig_count,      e.cnt);
                chk("ev_latency", cyc,             e.cyc);
                chk("ev_flag",    flag,            1);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        ch_sync      = 4'hF;
        ch_enable    = 4'hF;
        sgt          = 4'h0;
        readout_done = 1'b0;
        time_stamp   = 64'h0;
        time_stamp[0*16 +: 16] = 16'h0007;
        time_stamp[1*16 +: 16] = 16'h0011;
        time_stamp[2*16 +: 16] = 16'h0045;
        time_stamp[3*16 +: 16] = 16'h1234;

        tick(3);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick(3);

        // Single request on ch2, readout 10 cycles into ASSERT.
        c = cyc;
        sgt = 4'b0100;
        push(4'b0100, 16'h0045, 16'd1, c + 5);
        tick(1);
        sgt = 4'b0000;
        tick(3);
        chk("t1_flag_early", flag, 0);
        chk("t1_busy_coinc", busy, 1);
        tick(1);
        a = cyc;
        tick(9);
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        chk("t1_flag_fall", flag, 0);
        chk("t1_busy_dead", busy, 1);
        chk("t1_terr", timeout_err, 0);
        d = cyc;
        tick(15);
        chk("t1_dead_last", busy, 1);
        tick(1);
        chk("t1_dead_exit", busy, 0);
        chk("t1_hold_mask", trig_ch_mask, 4'b0100);
        chk("t1_hold_ts", trig_time_stamp, 16'h0045);
        tick(2);

        // Coincidence: ch3 first, ch0 two edges later, ch1 too late.
        // A readout_done during COINC must be ignored.
        c = cyc;
        sgt = 4'b1000;
        push(4'b1001, 16'h1234, 16'd2, c + 5);
        tick(1);
        sgt = 4'b0000;
        readout_done = 1'b1;
        time_stamp[3*16 +: 16] = 16'hBEEF;
        tick(1);
        readout_done = 1'b0;
        sgt = 4'b0001;
        tick(1);
        sgt = 4'b0000;
        tick(2);
        sgt = 4'b0010;
        tick(1);
        sgt = 4'b0000;
        chk("t2_late_excl", trig_ch_mask, 4'b1001);
        tick(1);
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        chk("t2_flag_fall", flag, 0);
        tick(17);
        chk("t2_idle", busy, 0);
        chk("t2_hold_mask", trig_ch_mask, 4'b1001);
        chk("t2_hold_ts", trig_time_stamp, 16'h1234);

        // Gating by ch_enable, then by ch_sync.
        ch_enable = 4'b1101;
        sgt = 4'b0010;
        tick(3);
        chk("t3_en_busy", busy, 0);
        sgt = 4'b0000;
        ch_enable = 4'hF;
        ch_sync = 4'b1101;
        sgt = 4'b0010;
        tick(3);
        chk("t3_sync_busy", busy, 0);
        sgt = 4'b0000;
        ch_sync = 4'hF;
        tick(1);
        chk("t3_count", trig_count, 16'd2);
        chk("t3_mask", trig_ch_mask, 4'b1001);

        // Timeout, request during DEAD ignored, held request retriggers.
        c = cyc;
        time_stamp[0*16 +: 16] = 16'h00AA;
        sgt = 4'b0001;
        push(4'b0001, 16'h00AA, 16'd3, c + 5);
        tick(1);
        sgt = 4'b0000;
        tick(4);
        a = cyc;
        tick(255);
        chk("t4_flag_last", flag, 1);
        chk("t4_terr_early", timeout_err, 0);
        tick(1);
        chk("t4_flag_to", flag, 0);
        chk("t4_terr_set", timeout_err, 1);
        chk("t4_busy_dead", busy, 1);
        d = cyc;
        tick(2);
        sgt = 4'b0100;
        tick(1);
        sgt = 4'b0000;
        tick(7);
        time_stamp[0*16 +: 16] = 16'h00BB;
        sgt = 4'b0001;
        push(4'b0001, 16'h00BB, 16'd4, d + 21);
        tick(5);
        chk("t4_dead_last", busy, 1);
        tick(1);
        chk("t4_dead_exit", busy, 0);
        tick(1);
        sgt = 4'b0000;
        chk("t4_retrig", busy, 1);
        tick(4);
        tick(10);
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        chk("t4_flag_rd", flag, 0);
        chk("t4_terr_sticky", timeout_err, 1);
        tick(17);
        chk("t4_idle", busy, 0);

        // Asynchronous reset in the middle of COINC.
        c = cyc;
        sgt = 4'b0010;
        tick(2);
        chk("t5_in_coinc", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t5");
        sgt = 4'b0000;
        tick(3);

        // Request held as reset releases is accepted on the first edge;
        // readout_done lands exactly on the MAX_WAIT expiry edge.
        c = cyc;
        rst_n = 1'b1;
        sgt = 4'b0100;
        push(4'b0100, 16'h0045, 16'd1, c + 5);
        tick(1);
        sgt = 4'b0000;
        tick(4);
        a = cyc;
        tick(255);
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        chk("t6_flag_fall", flag, 0);
        chk("t6_terr_clear", timeout_err, 0);
        chk("t6_busy_dead", busy, 1);
        tick(17);
        chk("t6_idle", busy, 0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/global_trigger_ctrl.md
GLOBAL_TRIGGER_CTRL -- requirements
Module: global_trigger_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 4, number of Thresholder channels; TS_W, default 16, time-stamp width; COINC_WIN, default 4, coincidence window in cycles (legal range 1..255); DEADTIME, default 16, post-trigger dead time in cycles (legal range 1..65535); MAX_WAIT, default 256, readout timeout in cycles (legal range 1..65535).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 rx_std_clkout  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ch_sync  in  NUM_CH  per-channel link-synced flag (both rx_syncstatus bits high).
REQ-006 ch_enable  in  NUM_CH  configuration mask; 1 = channel may trigger.
REQ-007 set_global_trigger  in  NUM_CH  per-channel threshold-crossing request, level.
REQ-008 time_stamp  in  NUM_CH*TS_W  packed per-channel time stamps; channel i occupies bits [i*TS_W +: TS_W].
REQ-009 readout_done  in  1  single-cycle pulse from readout logic marking event consumed.
REQ-010 Global_trigger_flag  out  1  broadcast to all Thresholders; high while an event is being read out.
REQ-011 trig_valid  out  1  single-cycle pulse; trig_ch_mask and trig_time_stamp are valid.
REQ-012 trig_ch_mask  out  NUM_CH  channels that requested within the coincidence window.
REQ-013 trig_time_stamp  out  TS_W  time stamp of the winning (first, lowest-index) channel.
REQ-014 trig_count  out  16  accepted-trigger counter; wraps from 16'hFFFF to 0.
REQ-015 timeout_err  out  1  sticky flag set on readout timeout.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The effective request SHALL be req = set_global_trigger & ch_enable & ch_sync; gated-off channels SHALL never appear in trig_ch_mask.
REQ-018 The FSM SHALL have states IDLE, COINC, ASSERT and DEAD.
REQ-019 Transition IDLE->COINC: at the first edge where req != 0, the FSM SHALL latch the lowest-index requesting channel's time_stamp into trig_time_stamp and load trig_ch_mask with req.
REQ-020 COINC duration: the FSM SHALL remain in COINC for exactly COINC_WIN cycles, OR-ing req into trig_ch_mask on every edge, then move to ASSERT.
REQ-021 trig_time_stamp SHALL NOT change during COINC, even if a lower-index channel requests later.
REQ-022 On entry to ASSERT: Global_trigger_flag SHALL rise on the same edge, trig_valid SHALL pulse for one cycle, and trig_count SHALL increment by 1.
REQ-023 Latency: with the first request sampled at edge k, Global_trigger_flag and trig_valid SHALL be high after edge k+COINC_WIN.
REQ-024 ASSERT->DEAD: on a readout_done pulse, or after MAX_WAIT cycles in ASSERT, whichever comes first.
REQ-025 On timeout, timeout_err SHALL be set; only reset clears it.
REQ-026 readout_done SHALL be ignored outside ASSERT.
REQ-027 Global_trigger_flag SHALL fall on entry to DEAD.
REQ-028 DEAD->IDLE: after exactly DEADTIME cycles in DEAD.
REQ-029 Requests in ASSERT or DEAD SHALL be discarded, not queued; a request still held on return to IDLE SHALL start a new event.
REQ-030 If readout_done and the MAX_WAIT expiry coincide, the transition SHALL be treated as normal completion and timeout_err SHALL NOT be set.
REQ-031 trig_ch_mask and trig_time_stamp SHALL hold their values until the next IDLE->COINC transition.

Reset
REQ-032 While rst_n is low, all registers SHALL clear immediately and the FSM SHALL be in IDLE.
REQ-033 Reset values: Global_trigger_flag=0, trig_valid=0, trig_ch_mask=0, trig_time_stamp=0, trig_count=0, timeout_err=0, busy=0.
REQ-034 A reset asserted during any state SHALL abort the event, with no trig_valid pulse.
REQ-035 The first request SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Verification
All scenarios use NUM_CH=4, COINC_WIN=4, DEADTIME=16, MAX_WAIT=256.
REQ-036 Single request: ch2 requests with time stamp 16'h0045 at edge k -> Global_trigger_flag and trig_valid high after k+4, trig_ch_mask=4'b0100, trig_time_stamp=16'h0045, trig_count=1.
REQ-037 Coincidence: ch3 at edge k, then ch0 at k+2 -> trig_ch_mask=4'b1001, trig_time_stamp=ch3's stamp; ch1 at k+5 is excluded.
REQ-038 Gating: ch1 requests with ch_enable[1]=0, and separately with ch_sync[1]=0 -> no busy, no trig_valid, trig_count unchanged.
REQ-039 Timeout and dead time: no readout_done -> flag falls after 256 ASSERT cycles, timeout_err=1; a request during the 16 DEAD cycles is ignored; a request held past DEAD triggers again.
REQ-040 Readout and reset: readout_done 10 cycles into ASSERT -> flag falls on the next edge and timeout_err stays 0; rst_n low mid-COINC -> all outputs return to reset values asynchronously.
